// File: rtl/keyboard_event_fifo_if.sv
// Event pop channel between keyboard_event_fifo and the game-control consumer.
// Show-ahead: evt_code is valid whenever evt_valid; evt_ready pops.
interface keyboard_event_fifo_if #(parameter int PTR_W = 3);
  logic             evt_valid;
  logic [3:0]       evt_code;
  logic             evt_ready;
  logic [PTR_W:0]   evt_count;

  modport master (output evt_valid, evt_code, evt_count, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_count, output evt_ready);
endinterface

// File: rtl/keyboard_event_fifo.sv
// Snapshots the keypad register, clears it once, then drains set bits lowest-first
// into a show-ahead event FIFO with sticky overflow.
module keyboard_event_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [15:0]           key_data,
  output logic                  key_clear,
  keyboard_event_fifo_if.master evt,
  output logic                  ovf,
  input  logic                  ovf_clear
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  state_t           state;
  logic [15:0]      mask;
  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [3:0]       lo_idx;
  logic             push_req, pop, full, push_ok, drop;

  // Scan high to low so the lowest set bit is the one left in lo_idx.
  always_comb begin
    lo_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (mask[i]) lo_idx = 4'(i);
  end

  // count tops out at 2**PTR_W, so its MSB alone means full.
  assign full     = count[PTR_W];
  assign pop      = evt.evt_valid && evt.evt_ready;
  assign push_req = (state == DRAIN) && (|mask);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  assign evt.evt_valid = |count;
  assign evt.evt_code  = mem[rd_ptr];
  assign evt.evt_count = count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      mask      <= '0;
      key_clear <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|key_data) begin
          mask      <= key_data;
          key_clear <= 1'b1;
          state     <= CLEAR;
        end
        CLEAR: begin
          // Fold in keys latched between the snapshot and the clear edge.
          mask      <= mask | key_data;
          key_clear <= 1'b0;
          state     <= DRAIN;
        end
        DRAIN: begin
          if (!(|mask)) state <= IDLE;
          else          mask[lo_idx] <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          key_clear <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= lo_idx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop)           ovf <= 1'b1;
      else if (ovf_clear) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keyboard_event_fifo.sv
// Bench for keyboard_event_fifo: snapshot vector table plus hand-written corner sequences,
// with popped codes checked against a scoreboard queue.
module tb_keyboard_event_fifo;
  localparam int PTR_W = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] key_data;
  logic        key_clear;
  logic        ovf;
  logic        ovf_clear;
  int          kc_cnt = 0;
  int          total = 0;
  int          bad = 0;
  int          sb_q[$];

  keyboard_event_fifo_if #(.PTR_W(PTR_W)) eif ();

  keyboard_event_fifo #(.FIFO_DEPTH(8), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_data  (key_data),
    .key_clear (key_clear),
    .evt       (eif.master),
    .ovf       (ovf),
    .ovf_clear (ovf_clear)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (key_clear) kc_cnt++;

  typedef struct {
    logic [15:0] keys;
    int          first;
    int          cnt;
    int          ov;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: compares the head of the FIFO if it pops on the next edge.
  task automatic sample_pop();
    int e;
    if (eif.evt_valid && eif.evt_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_evt", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("evt_code", int'(eif.evt_code), e);
      end
    end
  endtask

  task automatic drain();
    eif.evt_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!eif.evt_valid) break;
      sample_pop();
      @(negedge clk);
    end
    eif.evt_ready = 1'b0;
    chk("sb_left", sb_q.size(), 0);
    chk("drain_count", int'(eif.evt_count), 0);
    chk("drain_valid", int'(eif.evt_valid), 0);
  endtask

  // Called at a negedge with the DUT idle and the FIFO empty.
  task automatic run_vec(input vec_t v);
    int kb, n;
    kb = kc_cnt;
    n  = 0;
    for (int i = 0; i < 16; i++)
      if (v.keys[i] && n < v.cnt) begin
        sb_q.push_back(i);
        n++;
      end
    key_data = v.keys;
    @(posedge clk); #1;
    chk("kc_at_t0p1", int'(key_clear), 1);
    chk("valid_at_t0p1", int'(eif.evt_valid), 0);
    @(negedge clk); key_data = '0;
    @(posedge clk); #1;
    chk("kc_after_clear", int'(key_clear), 0);
    chk("valid_before_push", int'(eif.evt_valid), 0);
    @(posedge clk); #1;
    chk("valid_at_t0p2", int'(eif.evt_valid), 1);
    chk("code_at_t0p2", int'(eif.evt_code), v.first);
    chk("count_at_t0p2", int'(eif.evt_count), 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("count_final", int'(eif.evt_count), v.cnt);
    chk("ovf", int'(ovf), v.ov);
    chk("kc_pulses", kc_cnt - kb, 1);
    if (v.ov != 0) begin
      ovf_clear = 1'b1;
      @(negedge clk); ovf_clear = 1'b0;
      chk("ovf_cleared", int'(ovf), 0);
    end
    drain();
  endtask

  initial begin
    int kb;
    vecs[0] = '{keys: 16'h0010, first: 4,  cnt: 1, ov: 0};
    vecs[1] = '{keys: 16'h8421, first: 0,  cnt: 4, ov: 0};
    vecs[2] = '{keys: 16'h03FF, first: 0,  cnt: 8, ov: 1};
    vecs[3] = '{keys: 16'hFFFF, first: 0,  cnt: 8, ov: 1};
    vecs[4] = '{keys: 16'h8000, first: 15, cnt: 1, ov: 0};
    vecs[5] = '{keys: 16'h0180, first: 7,  cnt: 2, ov: 0};

    rstn = 1'b0; key_data = '0; ovf_clear = 1'b0; eif.evt_ready = 1'b0;
    #1;
    chk("rst_key_clear", int'(key_clear), 0);
    chk("rst_valid", int'(eif.evt_valid), 0);
    chk("rst_code", int'(eif.evt_code), 0);
    chk("rst_count", int'(eif.evt_count), 0);
    chk("rst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bit 7 lands during the CLEAR cycle and must be folded into the same snapshot.
    kb = kc_cnt;
    sb_q.push_back(1); sb_q.push_back(7);
    key_data = 16'h0002;
    @(posedge clk); #1;
    chk("late_kc", int'(key_clear), 1);
    @(negedge clk); key_data = 16'h0082;
    @(posedge clk); #1;
    chk("late_kc_drop", int'(key_clear), 0);
    @(negedge clk); key_data = '0;
    repeat (10) @(negedge clk);
    chk("late_count", int'(eif.evt_count), 2);
    chk("late_kc_pulses", kc_cnt - kb, 1);
    drain();

    // Full FIFO with concurrent pop each cycle: no drops, count pinned at 8, pointers wrap.
    key_data = 16'h00FF;
    for (int i = 0; i < 8; i++) sb_q.push_back(i);
    @(negedge clk); key_data = '0;
    repeat (12) @(negedge clk);
    chk("fill_count", int'(eif.evt_count), 8);
    kb = kc_cnt;
    key_data = 16'hFFF0;
    for (int i = 4; i < 16; i++) sb_q.push_back(i);
    @(negedge clk); key_data = '0;
    @(negedge clk);
    eif.evt_ready = 1'b1;
    sample_pop();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("full_pop_count", int'(eif.evt_count), 8);
      chk("full_pop_ovf", int'(ovf), 0);
      sample_pop();
    end
    @(negedge clk);
    drain();
    chk("full_kc_pulses", kc_cnt - kb, 1);
    chk("full_ovf_end", int'(ovf), 0);

    // Reset in the middle of a drain with three entries queued.
    key_data = 16'h000F;
    @(negedge clk); key_data = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_count", int'(eif.evt_count), 3);
    rstn = 1'b0;
    #1;
    chk("mid_rst_kc", int'(key_clear), 0);
    chk("mid_rst_valid", int'(eif.evt_valid), 0);
    chk("mid_rst_code", int'(eif.evt_code), 0);
    chk("mid_rst_count", int'(eif.evt_count), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    kb = kc_cnt;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", int'(eif.evt_valid), 0);
    chk("post_rst_count", int'(eif.evt_count), 0);
    chk("post_rst_kc", kc_cnt - kb, 0);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
